// File: rtl/arc4_encrypt_if.sv
// arc4_encrypt_if: en/rdy/key handshake plus S-box, plaintext and ciphertext RAM ports of arc4_encrypt
interface arc4_encrypt_if;
  logic en;
  logic rdy;
  logic [23:0] key;
  logic [7:0] s_addr;
  logic [7:0] s_rddata;
  logic [7:0] s_wrdata;
  logic s_wren;
  logic [7:0] pt_addr;
  logic [7:0] pt_rddata;
  logic [7:0] ct_addr;
  logic [7:0] ct_wrdata;
  logic ct_wren;
  modport master (
    output en, key, s_rddata, pt_rddata,
    input rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren
  );
  modport slave (
    input en, key, s_rddata, pt_rddata,
    output rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren
  );
endinterface

// File: rtl/arc4_encrypt.sv
// arc4_encrypt: ARC4 engine encrypting length-prefixed pt RAM into ct RAM (ports: clk, rst_n, bus = en/rdy/key + S/pt/ct RAM ports)
module arc4_encrypt (
  input logic clk,
  input logic rst_n,
  arc4_encrypt_if.slave bus
);
  typedef enum logic [2:0] {IDLE, INIT, KSA, LEN, PRGA, DONE} state_t;
  state_t state, state_n;
  logic [2:0] ph, ph_n;
  logic [7:0] i, i_n, j, j_n, k, k_n, len, len_n, si, si_n, sj, sj_n, pb, pb_n;
  logic [1:0] km, km_n;
  logic last, last_n;
  logic [23:0] key_r, key_n;
  logic rdy_n, s_wren_n, ct_wren_n;
  logic [7:0] s_addr_n, s_wrdata_n, pt_addr_n, ct_addr_n, ct_wrdata_n, kb;
  assign kb = km == 2'd0 ? key_r[23:16] : km == 2'd1 ? key_r[15:8] : key_r[7:0];
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      ph <= '0;
      i <= '0;
      j <= '0;
      k <= '0;
      len <= '0;
      si <= '0;
      sj <= '0;
      pb <= '0;
      km <= '0;
      last <= 1'b0;
      key_r <= '0;
      bus.rdy <= 1'b1;
      bus.s_addr <= '0;
      bus.s_wrdata <= '0;
      bus.s_wren <= 1'b0;
      bus.pt_addr <= '0;
      bus.ct_addr <= '0;
      bus.ct_wrdata <= '0;
      bus.ct_wren <= 1'b0;
    end else begin
      state <= state_n;
      ph <= ph_n;
      i <= i_n;
      j <= j_n;
      k <= k_n;
      len <= len_n;
      si <= si_n;
      sj <= sj_n;
      pb <= pb_n;
      km <= km_n;
      last <= last_n;
      key_r <= key_n;
      bus.rdy <= rdy_n;
      bus.s_addr <= s_addr_n;
      bus.s_wrdata <= s_wrdata_n;
      bus.s_wren <= s_wren_n;
      bus.pt_addr <= pt_addr_n;
      bus.ct_addr <= ct_addr_n;
      bus.ct_wrdata <= ct_wrdata_n;
      bus.ct_wren <= ct_wren_n;
    end
  always_comb begin
    state_n = state;
    ph_n = ph;
    i_n = i;
    j_n = j;
    k_n = k;
    len_n = len;
    si_n = si;
    sj_n = sj;
    pb_n = pb;
    km_n = km;
    last_n = last;
    key_n = key_r;
    rdy_n = 1'b0;
    s_wren_n = 1'b0;
    ct_wren_n = 1'b0;
    s_addr_n = bus.s_addr;
    s_wrdata_n = bus.s_wrdata;
    pt_addr_n = bus.pt_addr;
    ct_addr_n = bus.ct_addr;
    ct_wrdata_n = bus.ct_wrdata;
    case (state)
      IDLE: begin
        rdy_n = !bus.en;
        if (bus.en) begin
          key_n = bus.key;
          i_n = '0;
          j_n = '0;
          state_n = INIT;
          s_addr_n = '0;
          s_wrdata_n = '0;
          s_wren_n = 1'b1;
          pt_addr_n = '0;
          ct_addr_n = '0;
        end
      end
      INIT: begin
        i_n = i + 8'd1;
        s_addr_n = i + 8'd1;
        s_wrdata_n = i + 8'd1;
        s_wren_n = i != 8'hff;
        if (i == 8'hff) begin
          state_n = KSA;
          ph_n = '0;
          j_n = '0;
          km_n = '0;
        end
      end
      KSA, PRGA: begin
        ph_n = ph + 3'd1;
        if (state == PRGA && ph == 3'd0 && last) state_n = DONE;
        if (ph == 3'd1) begin
          si_n = bus.s_rddata;
          pb_n = bus.pt_rddata;
          j_n = j + bus.s_rddata + (state == KSA ? kb : 8'd0);
          s_addr_n = j_n;
        end
        if (ph == 3'd3) begin
          sj_n = bus.s_rddata;
          s_addr_n = j;
          s_wrdata_n = si;
          s_wren_n = 1'b1;
        end
        if (ph == 3'd4) begin
          s_addr_n = i;
          s_wrdata_n = sj;
          s_wren_n = 1'b1;
        end
        if (ph == 3'd5 && state == PRGA) s_addr_n = si + sj;
        if (ph == 3'd5 && state == KSA) begin
          ph_n = '0;
          i_n = i + 8'd1;
          km_n = km == 2'd2 ? 2'd0 : km + 2'd1;
          s_addr_n = i + 8'd1;
          state_n = i == 8'hff ? LEN : KSA;
          pt_addr_n = '0;
        end
        if (ph == 3'd7) begin
          ct_addr_n = k;
          ct_wrdata_n = pb ^ bus.s_rddata;
          ct_wren_n = 1'b1;
          last_n = k == len;
          if (k != len) begin
            k_n = k + 8'd1;
            i_n = i + 8'd1;
            s_addr_n = i + 8'd1;
            pt_addr_n = k + 8'd1;
          end
        end
      end
      LEN: begin
        ph_n = ph + 3'd1;
        if (ph == 3'd1) begin
          len_n = bus.pt_rddata;
          ct_addr_n = '0;
          ct_wrdata_n = bus.pt_rddata;
          ct_wren_n = 1'b1;
        end
        if (ph == 3'd2) begin
          ph_n = '0;
          state_n = len == 8'd0 ? DONE : PRGA;
          i_n = 8'd1;
          j_n = '0;
          k_n = 8'd1;
          last_n = 1'b0;
          s_addr_n = len == 8'd0 ? bus.s_addr : 8'd1;
          pt_addr_n = len == 8'd0 ? bus.pt_addr : 8'd1;
        end
      end
      DONE: begin
        rdy_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_arc4_encrypt.sv
// tb_arc4_encrypt: randomized self-checking bench for arc4_encrypt against a behavioural ARC4 model
module tb_arc4_encrypt;
  logic clk = 1'b0;
  logic rst_n;
  arc4_encrypt_if bus();
  arc4_encrypt dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  localparam logic [23:0] KV_KEY = 24'h4B6579;
  logic [7:0] s_mem [256];
  logic [7:0] pt_mem [256];
  logic [7:0] ct_mem [256];
  logic [7:0] exp_ct [256];
  logic [7:0] orig [256];
  logic [7:0] kv_ct [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  int checks = 0;
  int errors = 0;
  int ct_writes = 0;
  int viol = 0;
  logic [7:0] pt_max = '0;
  logic [7:0] len_seen = '0;
  logic ct_prev = 1'b0;
  always @(posedge clk) begin
    if (bus.s_wren) s_mem[bus.s_addr] <= bus.s_wrdata;
    bus.s_rddata <= bus.s_wren ? 8'hxx : s_mem[bus.s_addr];
    bus.pt_rddata <= pt_mem[bus.pt_addr];
    if (bus.ct_wren) ct_mem[bus.ct_addr] <= bus.ct_wrdata;
  end
  always @(posedge clk) begin
    if (!rst_n || (bus.rdy && bus.en)) begin
      ct_writes <= 0;
      pt_max <= '0;
    end else begin
      if (bus.ct_wren) ct_writes <= ct_writes + 1;
      if (bus.pt_addr > pt_max) pt_max <= bus.pt_addr;
    end
    if (bus.ct_wren && bus.ct_addr == 8'd0) len_seen <= bus.ct_wrdata;
    viol <= viol + int'(bus.ct_wren && ct_prev)
                 + int'(bus.ct_wren && bus.ct_addr != 8'd0 && bus.ct_addr > len_seen)
                 + int'(rst_n && bus.rdy && (bus.s_wren || bus.ct_wren));
    ct_prev <= bus.ct_wren;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic arc4_model(input logic [23:0] key);
    int s [256];
    int kb [3];
    int i = 0;
    int j = 0;
    int t;
    kb[0] = int'(key[23:16]);
    kb[1] = int'(key[15:8]);
    kb[2] = int'(key[7:0]);
    for (int n = 0; n < 256; n++) s[n] = n;
    for (int n = 0; n < 256; n++) begin
      j = (j + s[n] + kb[n % 3]) % 256;
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    j = 0;
    exp_ct[0] = pt_mem[0];
    for (int n = 1; n <= int'(pt_mem[0]); n++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      exp_ct[n] = pt_mem[n] ^ 8'(s[(s[i] + s[j]) % 256]);
    end
  endtask
  task automatic start(input string tag, input logic [23:0] k);
    int n = 0;
    while (!bus.rdy && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    bus.key = k;
    bus.en = 1'b1;
    @(posedge clk); #1;
    check({tag, "_accept"}, bus.rdy, 0);
  endtask
  task automatic wait_done(input string tag, input logic [23:0] new_key);
    int cyc = 0;
    int bound = 1798 + 8 * int'(pt_mem[0]);
    while (!bus.rdy && cyc < bound + 10) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 100) bus.key = new_key;
    end
    check({tag, "_latency_ok"}, bus.rdy && cyc <= bound, 1);
  endtask
  task automatic check_ct(input string tag);
    for (int n = 0; n <= int'(exp_ct[0]); n++) check($sformatf("%s_ct%0d", tag, n), ct_mem[n], exp_ct[n]);
    check({tag, "_ct_writes"}, ct_writes, int'(exp_ct[0]) + 1);
  endtask
  task automatic run(input string tag, input logic [23:0] k);
    arc4_model(k);
    start(tag, k);
    bus.en = 1'b0;
    wait_done(tag, k ^ 24'h5A5A5A);
    check_ct(tag);
  endtask
  task automatic load_known();
    string s = "Plaintext";
    pt_mem[0] = 8'd9;
    for (int n = 0; n < 9; n++) pt_mem[n + 1] = s[n];
  endtask
  task automatic check_known(input string tag);
    for (int n = 0; n < 10; n++) check($sformatf("%s_vec%0d", tag, n), ct_mem[n], kv_ct[n]);
  endtask
  initial begin
    logic [23:0] k2;
    rst_n = 1'b0;
    bus.en = 1'b0;
    bus.key = '0;
    for (int n = 0; n < 256; n++) pt_mem[n] = 8'($urandom);
    repeat (3) @(posedge clk); #1;
    check("rst_rdy", bus.rdy, 1);
    check("rst_wren", {bus.s_wren, bus.ct_wren}, 0);
    check("rst_addr_data", {bus.s_addr, bus.pt_addr, bus.ct_addr, bus.s_wrdata, bus.ct_wrdata}, 0);
    rst_n = 1'b1;
    load_known();
    run("kv", KV_KEY);
    check_known("kv");
    pt_mem[0] = 8'd0;
    run("l0", 24'($urandom));
    check("l0_pt_max", pt_max, 0);
    check("l0_rdy", bus.rdy, 1);
    for (int t = 0; t < 3; t++) begin
      pt_mem[0] = 8'($urandom_range(1, 48));
      for (int n = 1; n < 256; n++) pt_mem[n] = 8'($urandom);
      run($sformatf("rnd%0d", t), 24'($urandom));
    end
    pt_mem[0] = 8'd255;
    for (int n = 1; n < 256; n++) pt_mem[n] = 8'($urandom);
    for (int n = 0; n < 256; n++) orig[n] = pt_mem[n];
    run("rt1", 24'h1E4600);
    for (int n = 0; n < 256; n++) pt_mem[n] = ct_mem[n];
    run("rt2", 24'h1E4600);
    for (int n = 1; n < 256; n++) check($sformatf("rt_plain%0d", n), ct_mem[n], orig[n]);
    load_known();
    start("rs", KV_KEY);
    bus.en = 1'b0;
    repeat (499) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rs_rdy", bus.rdy, 1);
    check("rs_wren", {bus.s_wren, bus.ct_wren}, 0);
    check("rs_addr", {bus.s_addr, bus.pt_addr, bus.ct_addr}, 0);
    rst_n = 1'b1;
    run("rs_kv", KV_KEY);
    check_known("rs_kv");
    k2 = 24'($urandom);
    arc4_model(KV_KEY);
    start("hs", KV_KEY);
    wait_done("hs", k2);
    check_ct("hs");
    check_known("hs");
    @(posedge clk); #1;
    check("hs_b2b_accept", bus.rdy, 0);
    bus.en = 1'b0;
    arc4_model(k2);
    wait_done("hs2", k2);
    check_ct("hs2");
    repeat (2) @(posedge clk); #1;
    check("protocol_viol", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/arc4_encrypt.md
# arc4_encrypt

ARC4 encryption engine: takes a 24-bit key and a length-prefixed plaintext string held in an external plaintext RAM, generates the ARC4 keystream, and writes the length-prefixed ciphertext into an external ciphertext RAM. It is the producer for the ciphertext memories that the decryption and cracking blocks consume, and generates their test images in-system. It owns its own S-box RAM port, so it runs standalone with no shared init/ksa/prga instances. It is started and monitored through the same rdy/en handshake as the other ARC4 blocks.

## Interface
- No parameters. Key length is fixed at 3 bytes; memories are fixed at 256 x 8.
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- en  in  1  start request; accepted only on a rising edge where rdy=1
- rdy  out  1  high when idle and able to accept en
- key  in  24  ARC4 key; key[23:16] is key byte 0, key[7:0] is key byte 2; sampled on acceptance
- s_addr  out  8  S-box RAM address
- s_rddata  in  8  S-box read data, valid 1 cycle after s_addr (synchronous RAM)
- s_wrdata  out  8  S-box write data
- s_wren  out  1  S-box write enable
- pt_addr  out  8  plaintext RAM address
- pt_rddata  in  8  plaintext read data, 1-cycle read latency
- ct_addr  out  8  ciphertext RAM address
- ct_wrdata  out  8  ciphertext write data
- ct_wren  out  1  ciphertext write enable

## Operation
- Message format, both memories: byte 0 = length L (0..255); bytes 1..L = message.
- IDLE: rdy=1, all wren=0. On en=1, latch key, clear i and j, set rdy=0, and go to INIT.
- INIT: write S[i]=i for i=0..255, one write per cycle, in 256 cycles. Then go to KSA.
- KSA: set j=0. For i=0..255: j = j + S[i] + key[i mod 3] (mod 256), then swap S[i] and S[j]. The swap uses two writes: S[j] gets the old S[i], then S[i] gets the old S[j]. When i=j, the result is S unchanged. Use a fixed 6-cycle iteration.
- LEN: read pt[0] to get L and write ct[0]=L. If L=0, go to DONE.
- PRGA: set i=0 and j=0. For k=1..L:
  - i=i+1; j=j+S[i]; swap S[i] and S[j]
  - pad = S[(S[i]+S[j]) mod 256]
  - ct[k] = pt[k] XOR pad
  - Each byte takes at most 8 cycles.
  - The pt[k] read overlaps the S reads.
- DONE: one cycle, all wren=0. Then go to IDLE with rdy=1.
- All index arithmetic is 8-bit and wraps mod 256. L=255 writes ct[1..255], and the counter must not overflow into an extra write.
- en is ignored while busy. key changes after acceptance have no effect.
- pt memory is never written. ct addresses outside 0..L are never written.

## Timing
- Reset (rst_n=0 at an edge) has priority over everything, including mid-INIT/KSA/PRGA. Registered values at that edge: rdy=1, s_wren=0, ct_wren=0, and all addresses and write data = 0. State returns to IDLE on the next cycle and any partial ct contents are abandoned.
- Reset is synchronous: an asynchronous assertion between edges has no effect on outputs until the next edge.
- rdy falls on the edge after acceptance and rises on the edge that enters IDLE from DONE.
- Every wren pulse is exactly one cycle, with addr and wrdata valid in that same cycle.
- A read value is used only in the cycle after its address is presented. No read-after-write hazard is allowed: a write to S[x] completes before any later read of S[x].
- Total latency from the acceptance edge to rdy=1 is at most 256 + 256*6 + 8*L + 6 cycles. For L=9 this is 1870 cycles.
- Back-to-back operation: en may be held high. A new run is accepted on the first edge with rdy=1.

## Test plan
- Known vector: key=24'h4B6579 ("Key"), pt = 09 "Plaintext" -> ct = 09 BB F3 16 E8 D9 40 AF 0A D3. rdy=1 within 1870 cycles of acceptance.
- L=0, any key: exactly one ct write (addr 0, data 00), no pt reads beyond address 0, and rdy returns.
- Round trip: key=24'h1E4600 with a 255-byte random pt. Run once, copy ct into pt, and run again: the second ct[1..255] equals the original pt. No write to any address outside 0..255, and no wrap.
- Reset mid-KSA: pulse rst_n=0 for 1 cycle at acceptance+500. The next edge shows rdy=1 and all wren=0. A fresh run then produces the correct known-vector ct.
- Handshake: en held high through a run is ignored while rdy=0. Changing key mid-run does not alter ct. A second run starts on the first rdy=1 edge.
- Protocol checker in every test: each wren is one cycle; no S read of an address written in the same cycle; pt is never written.
